// File: rtl/uart_pkg.sv
// Shared types and constants for the AXI-stream UART transmitter.
// Build option AXIS_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

`ifdef AXIS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high on the last clock of every CLKS_PER_BIT period.
// restart realigns the period so a new frame always starts with a full bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of process order.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream to UART 8N1 transmitter; txd is registered, one byte per frame.
// Build option AXIS_UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd,
    output logic       busy
);

    tx_state_e  state, state_d;
    logic [7:0] shift, shift_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic       txd_d;
    logic       tick;
    logic       transfer;
`ifdef AXIS_UART_TX_PARITY_EN
    logic       parity, parity_d;
`endif

    assign iready   = (state == IDLE) && !reset;
    assign transfer = ivalid && iready;
    assign busy     = (state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock  (clock),
        .reset  (reset),
        .restart(transfer),
        .tick   (tick)
    );

    // NOTE: every signal written here gets a default first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        txd_d     = txd;
`ifdef AXIS_UART_TX_PARITY_EN
        parity_d  = parity;
`endif
        unique case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (transfer) begin
                    state_d = START;
                    shift_d = idata;
                    txd_d   = 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
                    parity_d = ^idata;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift[0];
                    shift_d = shift >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    // Index wraps 7->0 as the last data bit is left behind.
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef AXIS_UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d   = shift[0];
                        shift_d = shift >> 1;
                    end
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
`ifdef AXIS_UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            txd     <= txd_d;
`ifdef AXIS_UART_TX_PARITY_EN
            parity  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Scoreboard bench for axis_uart_tx at CLKS_PER_BIT=4; frame shape follows
// AXIS_UART_TX_PARITY_EN when that macro is defined for the build.
module tb_axis_uart_tx;

    localparam int N = 4;
`ifdef AXIS_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * N;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] idata = 8'h00;
    logic       ivalid = 1'b0;
    logic       iready;
    logic       txd;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]    exp_q[$];
    int            hs_log[$];
    int            hs_last = 0;
    int            frames_done = 0;
    logic          in_frame = 1'b0;
    int            k = 0;
    logic [NB-1:0] fbits = '1;

    axis_uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .idata (idata),
        .ivalid(ivalid),
        .iready(iready),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef AXIS_UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Handshake capture and serial-line scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        if (ivalid && iready) begin
            exp_q.push_back(idata);
            hs_log.push_back(cyc);
            hs_last = cyc;
        end
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && txd === 1'b0) begin
                check("frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) fbits = frame_bits(exp_q.pop_front());
                check("start_latency", cyc - hs_last, 1);
                in_frame = 1'b1;
                k = 0;
            end
            if (in_frame) begin
                if (k < F) begin
                    check("txd_bit", txd, fbits[k / N]);
                    check("busy_in_frame", busy, 1'b1);
                    check("iready_in_frame", iready, 1'b0);
                    k++;
                end else begin
                    check("txd_gap", txd, 1'b1);
                    check("busy_gap", busy, 1'b0);
                    check("iready_gap", iready, 1'b1);
                    in_frame = 1'b0;
                    frames_done++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int t;
        @(posedge clock);
        #1;
        idata  = d;
        ivalid = 1'b1;
        t = 0;
        while (!iready && t < 500) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("send_accepted", t < 500, 1'b1);
        @(posedge clock);
        #1;
        ivalid = 1'b0;
        idata  = 8'($urandom);
    endtask

    task automatic wait_hs(input int target);
        int t = 0;
        while (hs_log.size() < target && t < 500) begin
            @(negedge clock);
            t++;
        end
        check("handshake_timeout", t < 500, 1'b1);
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while ((exp_q.size() != 0 || in_frame) && t < 2000);
        check("drain_timeout", t < 2000, 1'b1);
    endtask

    initial begin
        int h0;
        int f0;

        // Reset state and release
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_iready", iready, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("iready_after_rst", iready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_txd", txd, 1'b1);
            check("idle_busy", busy, 1'b0);
        end

        // Single byte
        send(8'hA5);
        wait_done();

        // Back-to-back bytes with ivalid held
        h0 = hs_log.size();
        @(posedge clock);
        #1;
        idata  = 8'h00;
        ivalid = 1'b1;
        wait_hs(h0 + 1);
        @(posedge clock);
        #1 idata = 8'hFF;
        wait_hs(h0 + 2);
        @(posedge clock);
        #1 ivalid = 1'b0;
        wait_done();
        check("b2b_period", hs_log[h0+1] - hs_log[h0], NB * N + 1);

        // Reset in the middle of a frame
        f0 = frames_done;
        send(8'h3C);
        repeat (16) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_iready", iready, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_iready_release", iready, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            check("midrst_idle_txd", txd, 1'b1);
        end
        check("midrst_not_resent", frames_done, f0);
        check("midrst_queue_empty", exp_q.size(), 0);

        // Parity-distinguishing bytes
        send(8'h07);
        wait_done();
        send(8'h03);
        wait_done();

        // Input activity while busy must be ignored
        h0 = hs_log.size();
        f0 = frames_done;
        send(8'h55);
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            idata  = 8'($urandom);
            ivalid = 1'($urandom);
        end
        ivalid = 1'b0;
        wait_done();
        check("busy_input_handshakes", hs_log.size() - h0, 1);
        check("busy_input_frames", frames_done - f0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
